// File: rtl/v_gather_seq.sv
// ---------------------------------------------------------------------------
// v_gather_seq
//
// Sequenced gather of V-vector operands from the banked Y/V SRAMs.
// A start request latches the per-slot bank codes and clears all output
// slots. The block then runs one fetch phase per group of N_LINES slots.
// Each phase issues a single read strobe and waits RD_LAT cycles. It then
// captures the slots of that phase by steering the selected bank's readline
// into each slot. The completed set is held and offered to the Jacobi
// datapath over a valid/ready handshake.
//
// Ports
//   clock      : rising-edge clock
//   reset      : synchronous, active-high; aborts any sequence in progress
//   enable     : 0 freezes all state and forces rd_req low
//   start      : gather request, accepted in IDLE or in DONE with v_ready
//   bank_sel   : slot s bank code at [s*BANK_W +: BANK_W], latched on start
//   busy       : high while a gather is issuing, waiting or being offered
//   rd_req     : one-cycle SRAM read strobe for the current phase
//   phase      : phase index that accompanies rd_req
//   sram_rdata : bank b line l at [(b*N_LINES+l)*DATA_W +: DATA_W]
//   v_values   : slot s at [s*DATA_W +: DATA_W]
//   v_valid    : gathered set available
//   v_ready    : consumer takes v_values when v_valid & v_ready
// ---------------------------------------------------------------------------
module v_gather_seq #(
  parameter int DATA_W  = 48,
  parameter int N_BANKS = 4,
  parameter int N_LINES = 2,
  parameter int N_SLOTS = 4,
  parameter int BANK_W  = 3,
  parameter int RD_LAT  = 1,
  localparam int N_PHASES = (N_SLOTS + N_LINES - 1) / N_LINES,
  localparam int PHASE_W  = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 start,
  input  logic [N_SLOTS*BANK_W-1:0]            bank_sel,
  output logic                                 busy,
  output logic                                 rd_req,
  output logic [PHASE_W-1:0]                   phase,
  input  logic [N_BANKS*N_LINES*DATA_W-1:0]    sram_rdata,
  output logic [N_SLOTS*DATA_W-1:0]            v_values,
  output logic                                 v_valid,
  input  logic                                 v_ready
);

  localparam int CNT_W      = $clog2(RD_LAT + 1);
  localparam int LAST_PHASE = N_PHASES - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          wait_cnt;
  logic [N_SLOTS*BANK_W-1:0] sel_q;
  logic                      rd_req_q;

  // Readline steering for one slot. The line is fixed by the slot position.
  // The bank comes from the latched code. Codes outside the populated banks
  // produce zero rather than aliasing onto a real bank.
  function automatic logic [DATA_W-1:0] steer(
    input int                        s,
    input logic [N_SLOTS*BANK_W-1:0] sel,
    input logic [N_BANKS*N_LINES*DATA_W-1:0] rdata
  );
    logic [BANK_W-1:0] bank;
    int                line;
    logic [DATA_W-1:0] r;
    bank = sel[s*BANK_W +: BANK_W];
    line = s % N_LINES;
    r    = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (int'(bank) == b) begin
        r = rdata[(b*N_LINES + line)*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction

  // The strobe is held in a register. It is masked while stalled, so the
  // SRAM never sees a read that the sequencer is not advancing on.
  assign rd_req = rd_req_q & enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rd_req_q <= 1'b0;
      phase    <= '0;
      wait_cnt <= '0;
      v_valid  <= 1'b0;
      v_values <= '0;
      sel_q    <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (start) begin
            // Clearing the slots here keeps uncaptured phases at zero.
            // It also keeps them from showing the previous gather's data.
            sel_q    <= bank_sel;
            v_values <= '0;
            phase    <= '0;
            rd_req_q <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end

        ISSUE: begin
          rd_req_q <= 1'b0;
          wait_cnt <= CNT_W'(RD_LAT);
          state    <= WAIT;
        end

        WAIT: begin
          if (wait_cnt == CNT_W'(1)) begin
            // Only the slots belonging to the current phase are written.
            // Lines past N_SLOTS in a partial last phase have no slot.
            for (int s = 0; s < N_SLOTS; s++) begin
              if (int'(phase) == s / N_LINES) begin
                v_values[s*DATA_W +: DATA_W] <= steer(s, sel_q, sram_rdata);
              end
            end
            if (int'(phase) == LAST_PHASE) begin
              v_valid <= 1'b1;
              state   <= DONE;
            end else begin
              phase    <= phase + 1'b1;
              rd_req_q <= 1'b1;
              state    <= ISSUE;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        DONE: begin
          if (v_ready) begin
            v_valid <= 1'b0;
            if (start) begin
              // The hand-off and the next request share a cycle.
              // The next gather starts without passing through IDLE.
              sel_q    <= bank_sel;
              v_values <= '0;
              phase    <= '0;
              rd_req_q <= 1'b1;
              state    <= ISSUE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v_gather_seq.sv
// ---------------------------------------------------------------------------
// tb_v_gather_seq
//
// Directed bench for v_gather_seq.
// Instance a uses the default parameters.
// Instance b uses five slots and a two-cycle read latency.
// Each instance has a small SRAM model. It returns a readline pattern that
// is unique per phase, bank and line.
// ---------------------------------------------------------------------------
module tb_v_gather_seq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic enable;

  logic         a_start, a_busy, a_rd_req, a_v_valid, a_v_ready;
  logic [0:0]   a_phase;
  logic [11:0]  a_bank_sel;
  logic [383:0] a_rdata = '0;
  logic [191:0] a_vals;

  logic         b_start, b_busy, b_rd_req, b_v_valid, b_v_ready;
  logic [1:0]   b_phase;
  logic [14:0]  b_bank_sel;
  logic [383:0] b_rdata = '0;
  logic [239:0] b_vals;
  logic         b_pend = 1'b0;
  logic [1:0]   b_pend_ph = '0;

  int passed = 0;
  int total  = 0;

  int           rq_at [8];
  int           ph_at [8];
  int           n_rq;
  int           vv_at;
  logic [191:0] vals_k1;
  logic         valid_k1;
  logic [47:0]  ex [5];

  v_gather_seq u_a (
    .clock(clock), .reset(reset), .enable(enable), .start(a_start),
    .bank_sel(a_bank_sel), .busy(a_busy), .rd_req(a_rd_req), .phase(a_phase),
    .sram_rdata(a_rdata), .v_values(a_vals), .v_valid(a_v_valid), .v_ready(a_v_ready)
  );

  v_gather_seq #(.N_SLOTS(5), .RD_LAT(2)) u_b (
    .clock(clock), .reset(reset), .enable(enable), .start(b_start),
    .bank_sel(b_bank_sel), .busy(b_busy), .rd_req(b_rd_req), .phase(b_phase),
    .sram_rdata(b_rdata), .v_values(b_vals), .v_valid(b_v_valid), .v_ready(b_v_ready)
  );

  function automatic logic [47:0] pat(input int p, input int b, input int l);
    logic [7:0] hp, hb, hl;
    hp = 8'(192 + p);
    hb = 8'(176 + b);
    hl = 8'(208 + l);
    return {hp, hb, hl, 24'h5A5A5A};
  endfunction

  function automatic logic [383:0] line_bus(input int p);
    logic [383:0] r;
    r = '0;
    for (int b = 0; b < 4; b++)
      for (int l = 0; l < 2; l++)
        r[(b*2 + l)*48 +: 48] = pat(p, b, l);
    return r;
  endfunction

  // SRAM models: latency 1 for instance a, latency 2 for instance b.
  // Each readline holds until the next read.
  always @(posedge clock) begin
    if (a_rd_req) a_rdata <= line_bus(int'(a_phase));
  end

  always @(posedge clock) begin
    b_pend    <= b_rd_req;
    b_pend_ph <= b_phase;
    if (b_pend) b_rdata <= line_bus(int'(b_pend_ph));
  end

  task automatic observe_a(input int max, input int en_from, input int en_to);
    n_rq  = 0;
    vv_at = -1;
    for (int i = 0; i < 8; i++) begin rq_at[i] = -1; ph_at[i] = -1; end
    for (int k = 1; k <= max; k++) begin
      @(negedge clock);
      if (k == 1) begin
        vals_k1   = a_vals;
        valid_k1  = a_v_valid;
        a_start   = 1'b0;
        a_v_ready = 1'b0;
      end
      if (a_rd_req && n_rq < 8) begin
        rq_at[n_rq] = k;
        ph_at[n_rq] = int'(a_phase);
        n_rq++;
      end
      enable = !(k >= en_from && k <= en_to);
      if (a_v_valid) begin
        vv_at = k;
        break;
      end
    end
    enable = 1'b1;
  endtask

  task automatic observe_b(input int max);
    n_rq  = 0;
    vv_at = -1;
    for (int i = 0; i < 8; i++) begin rq_at[i] = -1; ph_at[i] = -1; end
    for (int k = 1; k <= max; k++) begin
      @(negedge clock);
      if (k == 1) b_start = 1'b0;
      if (b_rd_req && n_rq < 8) begin
        rq_at[n_rq] = k;
        ph_at[n_rq] = int'(b_phase);
        n_rq++;
      end
      if (b_v_valid) begin
        vv_at = k;
        break;
      end
    end
  endtask

  task automatic release_a();
    a_v_ready = 1'b1;
    @(negedge clock);
    a_v_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    a_start = 1'b0; a_v_ready = 1'b0; a_bank_sel = '0;
    b_start = 1'b0; b_v_ready = 1'b0; b_bank_sel = '0;
    repeat (3) @(negedge clock);
    total++; if ({a_busy, a_rd_req, a_v_valid} !== 3'b000) $display("FAIL reset_ctrl_a got %b want 000", {a_busy, a_rd_req, a_v_valid}); else passed++;
    total++; if (a_phase !== 1'b0) $display("FAIL reset_phase_a got %h want 0", a_phase); else passed++;
    total++; if (a_vals !== '0) $display("FAIL reset_vals_a got %h want 0", a_vals); else passed++;
    total++; if ({b_busy, b_rd_req, b_v_valid} !== 3'b000) $display("FAIL reset_ctrl_b got %b want 000", {b_busy, b_rd_req, b_v_valid}); else passed++;
    total++; if (b_vals !== '0) $display("FAIL reset_vals_b got %h want 0", b_vals); else passed++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_timing_a(input string nm, input int r1, input int want_vv);
    total++; if (n_rq !== 2) $display("FAIL %s_nreq got %0d want 2", nm, n_rq); else passed++;
    total++; if (rq_at[0] !== 1 || rq_at[1] !== r1) $display("FAIL %s_req_cycles got %0d,%0d want 1,%0d", nm, rq_at[0], rq_at[1], r1); else passed++;
    total++; if (ph_at[0] !== 0 || ph_at[1] !== 1) $display("FAIL %s_req_phase got %0d,%0d want 0,1", nm, ph_at[0], ph_at[1]); else passed++;
    total++; if (vv_at !== want_vv) $display("FAIL %s_valid_cycle got %0d want %0d", nm, vv_at, want_vv); else passed++;
  endtask

  task automatic test_basic_gather();
    a_bank_sel = {3'd3, 3'd2, 3'd1, 3'd0};
    a_start = 1'b1;
    observe_a(20, 0, -1);
    check_timing_a("basic", 3, 5);
    ex[0] = pat(0, 0, 0); ex[1] = pat(0, 1, 1); ex[2] = pat(1, 2, 0); ex[3] = pat(1, 3, 1);
    for (int s = 0; s < 4; s++) begin
      total++; if (a_vals[s*48 +: 48] !== ex[s]) $display("FAIL basic_slot%0d got %h want %h", s, a_vals[s*48 +: 48], ex[s]); else passed++;
    end
    total++; if (a_busy !== 1'b1) $display("FAIL basic_busy got %b want 1", a_busy); else passed++;
  endtask

  task automatic test_bank_zero();
    release_a();
    a_bank_sel = {3'd1, 3'd7, 3'd4, 3'd2};
    a_start = 1'b1;
    observe_a(20, 0, -1);
    total++; if (vv_at !== 5) $display("FAIL zero_valid_cycle got %0d want 5", vv_at); else passed++;
    ex[0] = pat(0, 2, 0); ex[1] = 48'h0; ex[2] = 48'h0; ex[3] = pat(1, 1, 1);
    for (int s = 0; s < 4; s++) begin
      total++; if (a_vals[s*48 +: 48] !== ex[s]) $display("FAIL zero_slot%0d got %h want %h", s, a_vals[s*48 +: 48], ex[s]); else passed++;
    end
  endtask

  task automatic test_hold_done();
    logic [191:0] held;
    held = a_vals;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      total++;
      if ({a_v_valid, a_rd_req, a_busy, a_vals} !== {1'b1, 1'b0, 1'b1, held})
        $display("FAIL hold_cycle%0d got v=%b r=%b b=%b %h want v=1 r=0 b=1 %h", k, a_v_valid, a_rd_req, a_busy, a_vals, held);
      else passed++;
      a_start = (k == 3);
    end
    a_v_ready = 1'b1;
    a_start = 1'b1;
    a_bank_sel = {3'd0, 3'd1, 3'd2, 3'd3};
    observe_a(20, 0, -1);
    total++; if (valid_k1 !== 1'b0) $display("FAIL restart_valid_drop got %b want 0", valid_k1); else passed++;
    total++; if (vals_k1 !== '0) $display("FAIL restart_cleared got %h want 0", vals_k1); else passed++;
    check_timing_a("restart", 3, 5);
    ex[0] = pat(0, 3, 0); ex[1] = pat(0, 2, 1); ex[2] = pat(1, 1, 0); ex[3] = pat(1, 0, 1);
    for (int s = 0; s < 4; s++) begin
      total++; if (a_vals[s*48 +: 48] !== ex[s]) $display("FAIL restart_slot%0d got %h want %h", s, a_vals[s*48 +: 48], ex[s]); else passed++;
    end
  endtask

  task automatic test_enable_stall();
    release_a();
    a_bank_sel = {3'd3, 3'd2, 3'd1, 3'd0};
    a_start = 1'b1;
    observe_a(30, 2, 4);
    check_timing_a("stall", 6, 8);
    ex[0] = pat(0, 0, 0); ex[1] = pat(0, 1, 1); ex[2] = pat(1, 2, 0); ex[3] = pat(1, 3, 1);
    for (int s = 0; s < 4; s++) begin
      total++; if (a_vals[s*48 +: 48] !== ex[s]) $display("FAIL stall_slot%0d got %h want %h", s, a_vals[s*48 +: 48], ex[s]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    release_a();
    a_bank_sel = {3'd3, 3'd2, 3'd1, 3'd0};
    a_start = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (a_vals[47:0] !== pat(0, 0, 0) || a_vals[191:96] !== '0)
      $display("FAIL midreset_partial got %h want slot0 %h and slots2-3 zero", a_vals, pat(0, 0, 0)); else passed++;
    total++; if ({a_busy, a_phase} !== 2'b11) $display("FAIL midreset_in_wait got busy=%b phase=%h want 1,1", a_busy, a_phase); else passed++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++; if ({a_busy, a_v_valid, a_rd_req} !== 3'b000) $display("FAIL midreset_ctrl got %b want 000", {a_busy, a_v_valid, a_rd_req}); else passed++;
    total++; if (a_vals !== '0 || a_phase !== 1'b0) $display("FAIL midreset_data got %h phase %h want 0", a_vals, a_phase); else passed++;
    @(negedge clock);
    total++; if (a_rd_req !== 1'b0 || a_busy !== 1'b0) $display("FAIL midreset_after got r=%b b=%b want 0,0", a_rd_req, a_busy); else passed++;
  endtask

  task automatic test_five_slots();
    b_bank_sel = {3'd1, 3'd3, 3'd2, 3'd1, 3'd0};
    b_start = 1'b1;
    observe_b(30);
    total++; if (n_rq !== 3) $display("FAIL five_nreq got %0d want 3", n_rq); else passed++;
    total++; if (rq_at[0] !== 1 || rq_at[1] !== 4 || rq_at[2] !== 7)
      $display("FAIL five_req_cycles got %0d,%0d,%0d want 1,4,7", rq_at[0], rq_at[1], rq_at[2]); else passed++;
    total++; if (ph_at[0] !== 0 || ph_at[1] !== 1 || ph_at[2] !== 2)
      $display("FAIL five_req_phase got %0d,%0d,%0d want 0,1,2", ph_at[0], ph_at[1], ph_at[2]); else passed++;
    total++; if (vv_at !== 10) $display("FAIL five_valid_cycle got %0d want 10", vv_at); else passed++;
    ex[0] = pat(0, 0, 0); ex[1] = pat(0, 1, 1); ex[2] = pat(1, 2, 0); ex[3] = pat(1, 3, 1); ex[4] = pat(2, 1, 0);
    for (int s = 0; s < 5; s++) begin
      total++; if (b_vals[s*48 +: 48] !== ex[s]) $display("FAIL five_slot%0d got %h want %h", s, b_vals[s*48 +: 48], ex[s]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_gather();
    test_bank_zero();
    test_hold_done();
    test_enable_stall();
    test_reset_mid();
    test_five_slots();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
